// File: rtl/sb_pkg.sv
// sb_pkg: opcodes, state encodings and rate helper shared by the Sound Blaster DSP/DMA block.
package sb_pkg;
  localparam logic [7:0] SB_CMD_DAC     = 8'h10;
  localparam logic [7:0] SB_CMD_TC      = 8'h40;
  localparam logic [7:0] SB_CMD_DMA8    = 8'h14;
  localparam logic [7:0] SB_CMD_HALT    = 8'hD0;
  localparam logic [7:0] SB_CMD_CONT    = 8'hD4;
  localparam logic [7:0] SB_CMD_SPK_ON  = 8'hD1;
  localparam logic [7:0] SB_CMD_SPK_OFF = 8'hD3;
  localparam logic [7:0] SB_CMD_VER     = 8'hE1;
  localparam logic [7:0] SB_CMD_TEST_W  = 8'hE4;
  localparam logic [7:0] SB_CMD_TEST_R  = 8'hE8;
  localparam logic [7:0] SB_RESET_ACK   = 8'hAA;
  localparam logic [7:0] SB_TC_RESET    = 8'hA6;
  localparam logic [7:0] SB_PCM_MID     = 8'h80;

  typedef enum logic [1:0] {PS_IDLE, PS_ARG1, PS_ARG2} sb_pstate_e;
  typedef enum logic [1:0] {DS_IDLE, DS_WAIT, DS_REQ, DS_PAUSED} sb_dstate_e;

  function automatic logic [13:0] sb_period(input logic [7:0] tc, input int scale);
    return 14'(scale * (256 - int'(tc)));
  endfunction
endpackage

// File: rtl/sb_dsp_dma_timer.sv
// sb_rate_timer: converts the time constant to a clock period and flags when the running count reaches it.
module sb_rate_timer import sb_pkg::*; #(
  parameter int TC_SCALE = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_tc,
  input  logic       i_clr,
  input  logic       i_run,
  output logic       o_exp
);
  logic [13:0] r_period;
  logic [13:0] r_cnt;

  assign o_exp = r_cnt >= r_period;

  // count saturates at the period so a stalled request never wraps the timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= sb_period(SB_TC_RESET, TC_SCALE);
      r_cnt    <= '0;
    end else begin
      r_period <= sb_period(i_tc, TC_SCALE);
      if (i_clr) r_cnt <= '0;
      else if (i_run && !o_exp) r_cnt <= r_cnt + 14'd1;
    end
  end
endmodule

// File: rtl/sb_dsp_dma.sv
// sb_dsp_dma: Sound Blaster DSP command parser, 2-entry read queue and paced 8-bit single-cycle DMA engine.
module sb_dsp_dma import sb_pkg::*; #(
  parameter int TC_SCALE = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reset_wr,
  input  logic       reset_wdata,
  input  logic       dsp_wr,
  input  logic [7:0] dsp_wdata,
  input  logic       data_rd,
  input  logic       stat_rd,
  input  logic       dack_n,
  input  logic       dma_wr,
  input  logic [7:0] dma_data,
  output logic [7:0] rd_data,
  output logic       rd_avail,
  output logic       wr_busy,
  output logic       drq,
  output logic       irq,
  output logic [7:0] pcm,
  output logic       pcm_valid
);
  sb_pstate_e       r_pst;
  sb_dstate_e       r_dst;
  logic [7:0]       r_cmd, r_tc, r_len_lo, r_test, r_pcm;
  logic [16:0]      r_len;
  logic             r_spk, r_drq, r_irq, r_pcm_valid, r_rst_arm;
  logic [1:0][7:0]  r_q;
  logic [1:0]       r_cnt;

  logic             w_dsp_rst, w_op, w_arg1, w_start, w_halt, w_cont, w_dac, w_accept;
  logic             w_tclr, w_trun, w_exp;
  logic [16:0]      w_len_dec;
  logic [1:0]       w_push_n;
  logic [7:0]       w_push0;
  logic [1:0][7:0]  w_q;
  logic [1:0]       w_cnt;

  assign w_dsp_rst = reset_wr && !reset_wdata && r_rst_arm;
  assign w_op      = dsp_wr && r_pst == PS_IDLE;
  assign w_arg1    = dsp_wr && r_pst == PS_ARG1;
  assign w_start   = dsp_wr && r_pst == PS_ARG2;
  assign w_halt    = w_op && dsp_wdata == SB_CMD_HALT;
  assign w_cont    = w_op && dsp_wdata == SB_CMD_CONT;
  assign w_dac     = w_arg1 && r_cmd == SB_CMD_DAC;
  assign w_accept  = dma_wr && r_dst == DS_REQ;
  assign w_len_dec = r_len - 17'd1;
  assign w_tclr    = w_start || (r_dst == DS_REQ && (dma_wr || w_halt));
  assign w_trun    = r_dst == DS_WAIT && !w_halt;

  assign w_push_n = w_dsp_rst ? 2'd1 :
                    (w_op && dsp_wdata == SB_CMD_VER) ? 2'd2 :
                    (w_op && dsp_wdata == SB_CMD_TEST_R) ? 2'd1 : 2'd0;
  assign w_push0  = w_dsp_rst ? SB_RESET_ACK : dsp_wdata == SB_CMD_VER ? 8'h02 : r_test;

  // pop first, then flush on DSP reset, then append up to two bytes; overflow is dropped
  always_comb begin
    w_q   = r_q;
    w_cnt = r_cnt;
    if (data_rd && r_cnt != 2'd0) begin
      w_q[0] = r_q[1];
      w_cnt  = r_cnt - 2'd1;
    end
    if (w_dsp_rst) w_cnt = 2'd0;
    if (w_push_n != 2'd0 && w_cnt != 2'd2) begin
      w_q[w_cnt[0]] = w_push0;
      w_cnt         = w_cnt + 2'd1;
    end
    if (w_push_n == 2'd2 && w_cnt != 2'd2) begin
      w_q[w_cnt[0]] = 8'h01;
      w_cnt         = w_cnt + 2'd1;
    end
  end

  sb_rate_timer #(.TC_SCALE(TC_SCALE)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_tc  (r_tc),
    .i_clr (w_tclr),
    .i_run (w_trun),
    .o_exp (w_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= '0;
      r_cnt       <= 2'd0;
      r_pst       <= PS_IDLE;
      r_dst       <= DS_IDLE;
      r_cmd       <= 8'h00;
      r_tc        <= SB_TC_RESET;
      r_len_lo    <= 8'h00;
      r_test      <= 8'h00;
      r_pcm       <= SB_PCM_MID;
      r_len       <= '0;
      r_spk       <= 1'b1;
      r_drq       <= 1'b0;
      r_irq       <= 1'b0;
      r_pcm_valid <= 1'b0;
      r_rst_arm   <= 1'b0;
    end else begin
      r_q         <= w_q;
      r_cnt       <= w_cnt;
      r_pcm_valid <= 1'b0;
      if (reset_wr) r_rst_arm <= reset_wdata;
      if (w_dsp_rst) begin
        r_pst <= PS_IDLE;
        r_dst <= DS_IDLE;
        r_drq <= 1'b0;
        r_irq <= 1'b0;
        r_len <= '0;
      end else begin
        if (dsp_wr)
          case (r_pst)
            PS_IDLE: begin
              if (dsp_wdata inside {SB_CMD_DAC, SB_CMD_TC, SB_CMD_DMA8, SB_CMD_TEST_W}) begin
                r_pst <= PS_ARG1;
                r_cmd <= dsp_wdata;
              end
              if (dsp_wdata == SB_CMD_SPK_ON) r_spk <= 1'b1;
              if (dsp_wdata == SB_CMD_SPK_OFF) r_spk <= 1'b0;
            end
            PS_ARG1: begin
              r_pst <= r_cmd == SB_CMD_DMA8 ? PS_ARG2 : PS_IDLE;
              if (r_cmd == SB_CMD_TC) r_tc <= dsp_wdata;
              if (r_cmd == SB_CMD_TEST_W) r_test <= dsp_wdata;
              if (r_cmd == SB_CMD_DMA8) r_len_lo <= dsp_wdata;
            end
            default: r_pst <= PS_IDLE;
          endcase
        if (w_dac || w_accept) begin
          r_pcm       <= w_dac ? dsp_wdata : dma_data;
          r_pcm_valid <= 1'b1;
        end
        if (stat_rd) r_irq <= 1'b0;
        if (w_start) begin
          r_len <= {1'b0, dsp_wdata, r_len_lo} + 17'd1;
          r_dst <= DS_WAIT;
          r_drq <= 1'b0;
          r_irq <= 1'b0;
        end else
          case (r_dst)
            DS_WAIT:
              if (w_halt) r_dst <= DS_PAUSED;
              else if (w_exp && dack_n) begin
                r_dst <= DS_REQ;
                r_drq <= 1'b1;
              end
            DS_REQ:
              if (dma_wr) begin
                r_len <= w_len_dec;
                r_drq <= 1'b0;
                if (w_len_dec == '0) begin
                  r_irq <= 1'b1;
                  r_dst <= DS_IDLE;
                end else r_dst <= w_halt ? DS_PAUSED : DS_WAIT;
              end else if (w_halt) begin
                r_drq <= 1'b0;
                r_dst <= DS_PAUSED;
              end
            DS_PAUSED: if (w_cont) r_dst <= DS_WAIT;
            default: ;
          endcase
      end
    end
  end

  assign rd_avail  = r_cnt != 2'd0;
  assign rd_data   = rd_avail ? r_q[0] : 8'h00;
  assign wr_busy   = 1'b0;
  assign drq       = r_drq;
  assign irq       = r_irq;
  assign pcm       = r_spk ? r_pcm : SB_PCM_MID;
  assign pcm_valid = r_pcm_valid;
endmodule

// File: doc/sb_dsp_dma.md
# sb_dsp_dma

Sound Blaster DSP command and 8-bit single-cycle DMA engine for the ISA-side FPGA. It sits downstream of the ISA strobe synchroniser and address decode, and upstream of the S/PDIF sample mixer. It parses host writes to the DSP ports and paces DMA requests from the programmed time constant. It runs the DRQ1/DACK1 handshake, delivers unsigned 8-bit PCM samples with a valid strobe, and raises IRQ7 on block completion.

## Interface
- TC_SCALE, 50, clk cycles per microsecond; sample period = TC_SCALE*(256-TC)
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset, asynchronous, active-low
- reset_wr  in  1  1-cycle strobe, host write to 226h
- reset_wdata  in  1  bit0 of data written to 226h
- dsp_wr  in  1  1-cycle strobe, host write to 22Ch
- dsp_wdata  in  8  data written to 22Ch
- data_rd  in  1  1-cycle strobe, host read of 22Ah completed
- stat_rd  in  1  1-cycle strobe, host read of 22Eh completed
- dack_n  in  1  synchronised ISA DACK1, active-low
- dma_wr  in  1  1-cycle strobe, IOW rising edge while dack_n=0
- dma_data  in  8  ISA data latched with dma_wr
- rd_data  out  8  22Ah value: head of output queue
- rd_avail  out  1  22Eh bit7: output queue non-empty
- wr_busy  out  1  22Ch bit7: always 0
- drq  out  1  ISA DRQ1
- irq  out  1  ISA IRQ7, level
- pcm  out  8  current unsigned sample
- pcm_valid  out  1  1-cycle strobe when pcm updates

## Operation
- Reset values:
  - drq=0, irq=0, pcm=80h, pcm_valid=0.
  - Output queue empty, so rd_avail=0 and rd_data=00h.
  - TC=A6h (≈11 kHz); length=0; speaker on; parser IDLE; DMA IDLE.
- DSP reset via 226h:
  - Writing 1 then 0 aborts DMA: drq=0, irq=0, length=0.
  - It also returns the parser to IDLE and flushes the queue.
  - It then enqueues AAh.
- Output queue: 2 entries. data_rd pops the head. A push while full is dropped.
- Command parser states:
  - IDLE: opcode decode.
  - ARG1 and ARG2: argument bytes.
  - Unknown opcodes are ignored; the parser stays in IDLE.
- Opcodes:
  - 10h: next byte goes to pcm, with pcm_valid.
  - 40h: next byte becomes TC.
  - 14h: next two bytes are len_lo and len_hi. Length = {hi,lo}+1 (17-bit); then start DMA.
  - D0h: pause DMA.
  - D4h: resume DMA.
  - D1h / D3h: speaker on / off. While the speaker is off, pcm is forced to 80h.
  - E1h: enqueue 02h, then 01h.
  - E4h: next byte is stored. E8h enqueues the stored byte.
- DMA states:
  - IDLE: leaves on 14h argument completion, to WAIT with the timer cleared.
  - WAIT: the timer counts up. When timer ≥ period and dack_n=1, go to REQ with drq=1.
  - REQ: on dma_wr, set drq=0, pcm=dma_data, pulse pcm_valid, and decrement length. If the new length is 0, set irq=1 and go to IDLE; otherwise go to WAIT with the timer cleared.
  - PAUSED: drq=0, timer held. D4h returns to WAIT.
- D0h received while in REQ: drq drops immediately. A dma_wr arriving in the same cycle is still accepted.
- irq stays high until stat_rd. If a new block completes on the same cycle as stat_rd, irq stays 1.
- 14h issued while DMA is active: restarts with the new length, and irq is cleared.
- dma_wr while not in REQ: ignored.

## Timing
- Period = TC_SCALE*(256-TC) clocks, computed into a 14-bit register. TC=00h gives 12800 clocks.
- drq rises exactly period+1 clocks after entering WAIT, provided dack_n=1.
- pcm and pcm_valid update 1 cycle after dma_wr or after the 10h argument write.
- irq rises in the same cycle pcm_valid fires for the final byte.
- Queue push/pop: visible on rd_data/rd_avail the cycle after the strobe. The AAh from a DSP reset appears 1 cycle after the reset_wdata=0 write.
- The entire DMA data path takes no cycles from clk-crossing logic; all inputs are pre-synchronised.

## Structure
- Package sb_pkg holds:
  - opcode localparams (SB_CMD_DAC=10h, SB_CMD_TC=40h, SB_CMD_DMA8=14h, SB_CMD_HALT=D0h, SB_CMD_CONT=D4h, SB_CMD_SPK_ON=D1h, SB_CMD_SPK_OFF=D3h, SB_CMD_VER=E1h, SB_CMD_TEST_W=E4h, SB_CMD_TEST_R=E8h)
  - parser and DMA state enums
  - SB_RESET_ACK=AAh
- Sub-module sb_rate_timer: TC → period multiply, counter, and expiry flag, with clear/hold inputs.
- The queue is inline, as 2 registers plus a count.

## Test plan
- Reset handshake: reset_wr with 1 then 0 -> rd_avail=1, rd_data=AAh. After data_rd, rd_avail=0.
- E1h -> reads return 02h then 01h. A third E1h issued while 2 entries are queued adds nothing.
- 40h,83h; 14h,03h,00h -> drq rises 50*125+1=6251 clocks after WAIT entry. 4 dma_wr bytes 11h,22h,33h,44h -> pcm follows each. irq=1 after the 4th; stat_rd clears irq.
- Mid-block: D0h while drq=1 -> drq=0 next cycle and the timer holds. D4h -> drq is reasserted after a full period; the remaining count is preserved.
- dack_n held 0 at timer expiry -> drq stays 0 until dack_n=1. A DSP reset mid-block -> drq=0, irq=0, and AAh is queued.
- D3h then 10h,F0h -> pcm=80h with pcm_valid. After D1h, 10h,F0h -> pcm=F0h.
